// File: rtl/auto_command_gen.sv
`default_nettype none
// ============================================================================
//  Module      : auto_command_gen
//  Description : Automatic driving command generator. Waits for the driving
//                controller to settle in wait-for-command, samples the
//                obstacle detectors once, issues a single one-hot command and
//                holds it until the controller accepts it or a timeout fires.
//  Revision    : 1.0 - initial release
// ============================================================================
module auto_command_gen #(
    parameter logic [31:0] SETTLE_CYCLES = 32'd1_000_000,
    parameter logic [15:0] ACK_TIMEOUT   = 16'd255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       front_detector,
    input  logic       back_detector,
    input  logic       left_detector,
    input  logic       right_detector,
    input  logic [1:0] semi_state,
    output logic       go_straight_command,
    output logic       turn_left_command,
    output logic       turn_right_command,
    output logic [1:0] fsm_state,
    output logic [7:0] cmd_count,
    output logic       error
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SETTLE = 2'b01,
        ST_DECIDE = 2'b10,
        ST_ISSUE  = 2'b11
    } state_t;

    // Terminal values of the settle counter and the acknowledge timer
    localparam logic [31:0] c_SETTLE_LAST = SETTLE_CYCLES - 32'd1;
    localparam logic [15:0] c_ACK_LAST    = ACK_TIMEOUT - 16'd1;

    state_t      r_state;
    logic [31:0] r_settle_cnt;
    logic [15:0] r_issue_tmr;
    logic        r_turn_pending;
    logic        r_go_straight;
    logic        r_turn_left;
    logic        r_turn_right;
    logic [7:0]  r_cmd_count;
    logic        r_error;

    logic w_ctrl_waiting;
    logic w_unused_back;

    assign w_ctrl_waiting = (semi_state == 2'b00);

    // The rear detector plays no part in any decision
    assign w_unused_back = back_detector;

    // Main control FSM: settle, decide, issue with acknowledge/timeout handling
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_settle_cnt   <= 32'd0;
            r_issue_tmr    <= 16'd0;
            r_turn_pending <= 1'b0;
            r_go_straight  <= 1'b0;
            r_turn_left    <= 1'b0;
            r_turn_right   <= 1'b0;
            r_cmd_count    <= 8'd0;
            r_error        <= 1'b0;
        end else if (!enable) begin
            // Disabling abandons any work in progress but keeps statistics
            r_state        <= ST_IDLE;
            r_settle_cnt   <= 32'd0;
            r_issue_tmr    <= 16'd0;
            r_turn_pending <= 1'b0;
            r_go_straight  <= 1'b0;
            r_turn_left    <= 1'b0;
            r_turn_right   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_settle_cnt <= 32'd0;
                    r_state      <= ST_SETTLE;
                end

                ST_SETTLE: begin
                    // Any controller activity restarts the settle window
                    if (!w_ctrl_waiting) begin
                        r_settle_cnt <= 32'd0;
                    end else if (r_settle_cnt == c_SETTLE_LAST) begin
                        r_settle_cnt <= 32'd0;
                        r_state      <= ST_DECIDE;
                    end else begin
                        r_settle_cnt <= r_settle_cnt + 32'd1;
                    end
                end

                ST_DECIDE: begin
                    // A dead end is escaped by two consecutive left turns
                    r_issue_tmr <= 16'd0;
                    r_state     <= ST_ISSUE;
                    if (r_turn_pending) begin
                        r_turn_left    <= 1'b1;
                        r_turn_pending <= 1'b0;
                    end else if (!right_detector) begin
                        r_turn_right <= 1'b1;
                    end else if (!front_detector) begin
                        r_go_straight <= 1'b1;
                    end else if (!left_detector) begin
                        r_turn_left <= 1'b1;
                    end else begin
                        r_turn_left    <= 1'b1;
                        r_turn_pending <= 1'b1;
                    end
                end

                ST_ISSUE: begin
                    // Acceptance is checked first so it wins over a timeout
                    if (!w_ctrl_waiting) begin
                        r_go_straight <= 1'b0;
                        r_turn_left   <= 1'b0;
                        r_turn_right  <= 1'b0;
                        r_cmd_count   <= r_cmd_count + 8'd1;
                        r_issue_tmr   <= 16'd0;
                        r_state       <= ST_SETTLE;
                    end else if (r_issue_tmr == c_ACK_LAST) begin
                        r_go_straight  <= 1'b0;
                        r_turn_left    <= 1'b0;
                        r_turn_right   <= 1'b0;
                        r_error        <= 1'b1;
                        r_turn_pending <= 1'b0;
                        r_issue_tmr    <= 16'd0;
                        r_state        <= ST_SETTLE;
                    end else begin
                        r_issue_tmr <= r_issue_tmr + 16'd1;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign go_straight_command = r_go_straight;
    assign turn_left_command   = r_turn_left;
    assign turn_right_command  = r_turn_right;
    assign fsm_state           = r_state;
    assign cmd_count           = r_cmd_count;
    assign error               = r_error;

endmodule
`default_nettype wire

// File: tb/tb_auto_command_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_auto_command_gen
//  Description : Directed self-checking bench for auto_command_gen with a
//                queue of expected commands filled as detectors are driven.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_auto_command_gen;

    localparam logic [2:0] c_none     = 3'b000;
    localparam logic [2:0] c_right    = 3'b001;
    localparam logic [2:0] c_left     = 3'b010;
    localparam logic [2:0] c_straight = 3'b100;

    logic       clk;
    logic       rst;
    logic       enable;
    logic       front_detector;
    logic       back_detector;
    logic       left_detector;
    logic       right_detector;
    logic [1:0] semi_state;
    logic       go_straight_command;
    logic       turn_left_command;
    logic       turn_right_command;
    logic [1:0] fsm_state;
    logic [7:0] cmd_count;
    logic       error;

    logic [2:0] cmd;
    assign cmd = {go_straight_command, turn_left_command, turn_right_command};

    int         n_cmp = 0;
    int         n_err = 0;
    logic       model_pend = 1'b0;
    logic [2:0] exp_q[$];

    auto_command_gen #(
        .SETTLE_CYCLES(32'd4),
        .ACK_TIMEOUT  (16'd8)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .enable             (enable),
        .front_detector     (front_detector),
        .back_detector      (back_detector),
        .left_detector      (left_detector),
        .right_detector     (right_detector),
        .semi_state         (semi_state),
        .go_straight_command(go_straight_command),
        .turn_left_command  (turn_left_command),
        .turn_right_command (turn_right_command),
        .fsm_state          (fsm_state),
        .cmd_count          (cmd_count),
        .error              (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference decision: pending left turn, then right, straight, left
    function automatic logic [2:0] model_decide(input logic f, input logic l, input logic r);
        if (model_pend) begin
            model_pend = 1'b0;
            return c_left;
        end
        if (!r) return c_right;
        if (!f) return c_straight;
        if (!l) return c_left;
        model_pend = 1'b1;
        return c_left;
    endfunction

    task automatic set_det(input logic f, input logic l, input logic r);
        front_detector = f;
        left_detector  = l;
        right_detector = r;
        exp_q.push_back(model_decide(f, l, r));
    endtask

    // Wait (bounded) for a command, check its latency, then pop and compare
    task automatic wait_cmd(input string tag, input int exp_lat);
        int         lat;
        logic [2:0] e;
        lat = 0;
        while (cmd == c_none && lat < 20) begin
            tick(1);
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        if (exp_q.size() == 0) e = 3'b111;
        else e = exp_q.pop_front();
        check({tag, "_cmd"}, 32'(cmd), 32'(e));
        check({tag, "_st"}, 32'(fsm_state), 32'(2'b11));
    endtask

    task automatic accept(input string tag, input logic [1:0] s, input logic [7:0] exp_cnt);
        semi_state = s;
        tick(1);
        check({tag, "_clr"}, 32'(cmd), 32'(c_none));
        check({tag, "_cnt"}, 32'(cmd_count), 32'(exp_cnt));
        check({tag, "_st"}, 32'(fsm_state), 32'(2'b01));
        semi_state = 2'b00;
    endtask

    initial begin
        int hi;
        rst = 1'b1; enable = 1'b0; semi_state = 2'b00;
        front_detector = 1'b0; back_detector = 1'b0;
        left_detector = 1'b0; right_detector = 1'b0;
        tick(2);
        check("rst_st", 32'(fsm_state), 32'(2'b00));
        check("rst_cmd", 32'(cmd), 32'(c_none));
        check("rst_cnt", 32'(cmd_count), 32'd0);
        check("rst_err", 32'(error), 32'd0);
        rst = 1'b0;
        tick(1);

        // Right free; rear detector asserted to show it is ignored
        back_detector = 1'b1;
        set_det(1'b1, 1'b1, 1'b0);
        enable = 1'b1;
        tick(1);
        check("s1_settle", 32'(fsm_state), 32'(2'b01));
        wait_cmd("s1", 5);
        accept("s1_acc", 2'b10, 8'd1);

        // Right blocked, front free
        back_detector = 1'b0;
        set_det(1'b0, 1'b0, 1'b1);
        wait_cmd("s2", 5);
        accept("s2_acc", 2'b11, 8'd2);

        // Dead end: forced second left, then normal decision
        set_det(1'b1, 1'b1, 1'b1);
        wait_cmd("s3a", 5);
        accept("s3a_acc", 2'b01, 8'd3);
        set_det(1'b0, 1'b0, 1'b0);
        wait_cmd("s3b", 5);
        accept("s3b_acc", 2'b01, 8'd4);
        set_det(1'b0, 1'b0, 1'b0);
        wait_cmd("s3c", 5);
        accept("s3c_acc", 2'b10, 8'd5);

        // Acceptance on the same edge as the timeout: acceptance wins
        set_det(1'b0, 1'b1, 1'b0);
        wait_cmd("col", 5);
        tick(7);
        check("col_hold", 32'(cmd), 32'(c_right));
        accept("col_acc", 2'b01, 8'd6);
        check("col_err", 32'(error), 32'd0);

        // No acceptance on a dead-end turn: timeout also drops the pending turn
        set_det(1'b1, 1'b1, 1'b1);
        wait_cmd("to", 5);
        hi = 0;
        while (cmd != c_none && hi < 20) begin
            hi++;
            tick(1);
        end
        model_pend = 1'b0;
        check("to_len", 32'(hi), 32'd8);
        check("to_err", 32'(error), 32'd1);
        check("to_cnt", 32'(cmd_count), 32'd6);
        check("to_st", 32'(fsm_state), 32'(2'b01));
        set_det(1'b0, 1'b0, 1'b0);
        wait_cmd("to_next", 5);
        accept("to_next_acc", 2'b11, 8'd7);
        check("to_sticky", 32'(error), 32'd1);

        // Settle restart: controller glitch at settle count 2
        set_det(1'b1, 1'b0, 1'b1);
        tick(2);
        semi_state = 2'b11;
        tick(1);
        semi_state = 2'b00;
        wait_cmd("rs", 5);
        accept("rs_acc", 2'b10, 8'd8);

        // Enable drop on the same edge as acceptance: enable wins
        set_det(1'b0, 1'b0, 1'b1);
        wait_cmd("en_col", 5);
        enable = 1'b0;
        semi_state = 2'b10;
        tick(1);
        model_pend = 1'b0;
        check("en_col_st", 32'(fsm_state), 32'(2'b00));
        check("en_col_cmd", 32'(cmd), 32'(c_none));
        check("en_col_cnt", 32'(cmd_count), 32'd8);
        check("en_col_err", 32'(error), 32'd1);

        // Enable drop mid-SETTLE clears the settle counter
        semi_state = 2'b00;
        enable = 1'b1;
        tick(1);
        tick(2);
        enable = 1'b0;
        tick(1);
        check("en_drop_st", 32'(fsm_state), 32'(2'b00));
        check("en_drop_cmd", 32'(cmd), 32'(c_none));
        check("en_drop_cnt", 32'(cmd_count), 32'd8);
        set_det(1'b1, 1'b1, 1'b0);
        enable = 1'b1;
        tick(1);
        wait_cmd("re_en", 5);

        // Reset mid-ISSUE drops everything on that edge
        rst = 1'b1;
        tick(1);
        check("rst2_st", 32'(fsm_state), 32'(2'b00));
        check("rst2_cmd", 32'(cmd), 32'(c_none));
        check("rst2_cnt", 32'(cmd_count), 32'd0);
        check("rst2_err", 32'(error), 32'd0);
        enable = 1'b0;
        rst = 1'b0;
        tick(2);
        check("post_idle", 32'(fsm_state), 32'(2'b00));
        check("q_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
